// File: rtl/exe_muldiv.sv
`timescale 1ns/1ps
// exe_muldiv: iterative unsigned multiply / divide unit for the EX stage.
// One shift-add (multiply) or restoring (divide) step per cycle, XLEN steps
// per operation, then a single DONE cycle in which result_o is valid.
//
// Ports:
//   clk_i      rising-edge clock
//   rst_n_i    asynchronous active-low reset
//   start_i    ID/EX holds a mul/div instruction
//   op_i       00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   a_i, b_i   operands (latched on the start edge)
//   flush_i    abandon any operation, return to IDLE
//   suspend_o  stall request to PC, IF/ID and ID/EX
//   busy_o     state is not IDLE
//   done_o     result_o valid this cycle
//   result_o   registered result, held until the next completed operation
module exe_muldiv #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            suspend_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]     a_q, a_d;       // multiplier (shifts right) / dividend (shifts left)
  logic [XLEN-1:0]     b_q, b_d;       // multiplicand / divisor
  logic [2*XLEN-1:0]   acc_q, acc_d;   // product, or {remainder, quotient}
  logic [XLEN-1:0]     result_q, result_d;

  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       div_shift;
  logic [XLEN:0]       div_sub;
  logic                div_ge;
  logic [2*XLEN-1:0]   acc_step;
  logic [XLEN-1:0]     a_step;
  logic                last_step;

  // One iteration of the datapath. op_q[1] selects divide.
  always_comb begin
    // Multiply: add multiplicand into the upper half when the multiplier LSB
    // is set, then shift the whole {carry, acc} right by one.
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (a_q[0] ? {1'b0, b_q} : '0);

    // Divide: remainder always stays below the divisor, so when the shifted
    // remainder overflows into bit XLEN it is certainly >= divisor; otherwise
    // the borrow of the XLEN+1-bit subtraction decides.
    div_shift = {acc_q[2*XLEN-1:XLEN], a_q[XLEN-1]};
    div_sub   = {1'b0, div_shift[XLEN-1:0]} - {1'b0, b_q};
    div_ge    = div_shift[XLEN] | ~div_sub[XLEN];

    if (op_q[1]) begin
      acc_step = {(div_ge ? div_sub[XLEN-1:0] : div_shift[XLEN-1:0]),
                  acc_q[XLEN-2:0], div_ge};
      a_step   = {a_q[XLEN-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
      a_step   = {1'b0, a_q[XLEN-1:1]};
    end

    last_step = (cnt_q == CNT_W'(XLEN-1));
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          state_d = S_CALC;
          op_d    = op_i;
          a_d     = a_i;
          b_d     = b_i;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      S_CALC: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d = acc_step;
          a_d   = a_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_step) begin
            state_d = S_DONE;
            cnt_d   = '0;
            // MUL/DIVU take the low half (product low / quotient),
            // MULHU/REMU the high half (product high / remainder).
            result_d = op_q[0] ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign suspend_o = start_i & (state_q != S_DONE) & ~flush_i;
  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = (state_q == S_DONE);
  assign result_o  = result_q;

endmodule

// File: tb/tb_exe_muldiv.sv
`timescale 1ns/1ps
module tb_exe_muldiv;
  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        suspend, busy, done;
  logic [31:0] result;

  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          done_cyc = -1;
  logic [31:0] exp_res = '0;

  exe_muldiv #(.XLEN(32), .CNT_W(5)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .start_i   (start),
    .op_i      (op),
    .a_i       (a),
    .b_i       (b),
    .flush_i   (flush),
    .suspend_o (suspend),
    .busy_o    (busy),
    .done_o    (done),
    .result_o  (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    logic [63:0] p;
    p = {32'b0, x} * {32'b0, y};
    case (o)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (y == 0) ? 32'hFFFF_FFFF : x / y;
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  // Called just after a rising edge with the unit idle. Cycle 0 is the first
  // cycle start is seen; flush_at < 0 means no flush. After a flush the
  // instruction is considered killed and start drops.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int flush_at);
    bit          killed;
    logic [31:0] want;
    killed = 0;
    want   = ref_model(o, x, y);
    start  = 1'b1;
    op     = o;
    a      = x;
    b      = y;
    for (int cyc = 0; cyc <= XLEN + 1; cyc++) begin
      flush = (cyc == flush_at);
      if (killed) start = 1'b0;
      if (cyc > 0) begin
        op = 2'($urandom);
        a  = $urandom;
        b  = $urandom;
      end
      @(negedge clk);
      if (!killed && cyc == XLEN + 1) begin
        exp_res  = want;
        done_cyc = cycle;
      end
      check("suspend", 32'(suspend), 32'((!killed && !flush && cyc <= XLEN) ? 1 : 0));
      check("busy",    32'(busy),    32'((!killed && cyc >= 1) ? 1 : 0));
      check("done",    32'(done),    32'((!killed && cyc == XLEN + 1) ? 1 : 0));
      check("result",  result, exp_res);
      if (flush) killed = 1;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    flush = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          t1;
    logic [1:0]  o;
    logic [31:0] x, y;
    int          fa;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_suspend0", 32'(suspend), 32'd0);
    start = 1'b1;
    #1;
    check("rst_suspend1", 32'(suspend), 32'd1);
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases
    run_op(2'd0, 32'd7, 32'd6, -1);
    check("mul7x6", result, 32'h0000_002A);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    check("mulhu_ff", result, 32'hFFFF_FFFE);
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    check("mul_ff", result, 32'h0000_0001);
    run_op(2'd2, 32'd100, 32'd7, -1);
    check("divu100_7", result, 32'd14);
    run_op(2'd3, 32'd100, 32'd7, -1);
    check("remu100_7", result, 32'd2);
    run_op(2'd2, 32'd5, 32'd0, -1);
    check("divu_by0", result, 32'hFFFF_FFFF);
    run_op(2'd3, 32'd5, 32'd0, -1);
    check("remu_by0", result, 32'd5);
    run_op(2'd2, 32'd1000, 32'd3, 10);       // flush mid-CALC
    check("flush_hold", result, 32'd5);
    run_op(2'd0, 32'd9, 32'd9, 0);           // flush with start in IDLE
    run_op(2'd0, 32'd9, 32'd9, XLEN + 1);    // flush in DONE: result kept
    check("flush_done", result, 32'd81);

    // Reset mid-operation at cycle 15
    start = 1'b1; op = 2'd2; a = 32'd12345; b = 32'd17;
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_suspend", 32'(suspend), 32'd1);
    start = 1'b0;
    #1;
    check("mid_rst_suspend0", 32'(suspend), 32'd0);
    exp_res = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back MULs with the pipeline's IDLE cycle in between
    run_op(2'd0, 32'd3, 32'd4, -1);
    check("b2b_first", result, 32'd12);
    t1 = done_cyc;
    idle_cycle();
    run_op(2'd0, 32'd5, 32'd5, -1);
    check("b2b_second", result, 32'd25);
    check("b2b_gap", 32'(done_cyc - t1), 32'd35);

    // Randomized operations, operand mix biased toward edge values
    for (int n = 0; n < 60; n++) begin
      o = 2'($urandom_range(0, 3));
      x = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
      case ($urandom_range(0, 7))
        0:       y = 32'd0;
        1, 2:    y = 32'($urandom_range(1, 20));
        3:       y = 32'hFFFF_FFFF;
        default: y = $urandom;
      endcase
      fa = ($urandom_range(0, 7) == 0) ? $urandom_range(0, XLEN + 1) : -1;
      run_op(o, x, y, fa);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
